log_entry_fetch_ctrl: RTL and testbench

//  Upstream stage of the log reader output path. Takes a request for N consecutive log

---
 rtl/log_entry_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_log_entry_fetch_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_entry_fetch_ctrl.sv
// Log entry fetch controller: reads one fixed-size log slot per entry and forwards
// only the beats that hold entry data into the write-header FIFO.
module log_entry_fetch_ctrl #(
    parameter int unsigned DATA_W          = 512,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned IDX_W           = 16,
    parameter int unsigned LEN_W           = 16,
    parameter logic [ADDR_W-1:0] LOG_BASE_ADDR = '0,
    parameter int unsigned SLOT_BYTES_LOG2 = 10,
    parameter int unsigned LOG_SLOTS_LOG2  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_val,
    input  logic [IDX_W-1:0]  req_start_idx,
    input  logic [IDX_W-1:0]  req_num_entries,
    output logic              req_rdy,
    output logic              mem_rd_req_val,
    output logic [ADDR_W-1:0] mem_rd_req_addr,
    output logic [ADDR_W-1:0] mem_rd_req_size,
    input  logic              mem_rd_req_rdy,
    input  logic              mem_rd_resp_val,
    input  logic [DATA_W-1:0] mem_rd_resp_data,
    input  logic              mem_rd_resp_last,
    output logic              mem_rd_resp_rdy,
    output logic              fifo_wr_val,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              fifo_wr_last,
    output logic              fifo_wr_entry_last,
    input  logic              fifo_wr_rdy,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BEAT_BYTES      = DATA_W / 8;
    localparam int unsigned BEAT_LOG2       = $clog2(BEAT_BYTES);
    localparam int unsigned SLOT_BEATS_LOG2 = SLOT_BYTES_LOG2 - BEAT_LOG2;
    localparam int unsigned SLOT_BEATS      = 1 << SLOT_BEATS_LOG2;
    localparam int unsigned CNT_W           = SLOT_BEATS_LOG2 + 1;
    localparam int unsigned SUM_W           = LEN_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        DATA   = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  cur_idx;
    logic [IDX_W-1:0]  remaining;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  need_q;

    logic [SUM_W-1:0]  len_sum;
    logic [SUM_W-1:0]  len_beats;
    logic [CNT_W-1:0]  need_len;
    logic [CNT_W-1:0]  need_cur;
    logic              last_cur;
    logic              in_data;
    logic              xfer;

    // Beats needed by the entry, from the length field carried in beat 0
    assign len_sum   = SUM_W'(mem_rd_resp_data[LEN_W-1:0]) + SUM_W'(BEAT_BYTES - 1);
    assign len_beats = len_sum >> BEAT_LOG2;
    assign need_len  = (len_beats == '0)                 ? CNT_W'(1) :
                       (len_beats > SUM_W'(SLOT_BEATS))  ? CNT_W'(SLOT_BEATS) :
                                                           CNT_W'(len_beats);

    // Beat 0 uses the freshly decoded length; later beats use the registered copy
    assign need_cur = (beat_cnt == '0) ? need_len : need_q;
    assign last_cur = (beat_cnt == CNT_W'(need_cur - CNT_W'(1))) | mem_rd_resp_last;

    // State-decoded control outputs
    assign req_rdy         = (state == IDLE);
    assign busy            = (state != IDLE);
    assign done            = (state == FINISH);
    assign mem_rd_req_val  = (state == ISSUE);
    assign mem_rd_req_addr = mem_rd_req_val
                           ? LOG_BASE_ADDR + (ADDR_W'(cur_idx[LOG_SLOTS_LOG2-1:0]) << SLOT_BYTES_LOG2)
                           : '0;
    assign mem_rd_req_size = mem_rd_req_val ? (ADDR_W'(1) << SLOT_BYTES_LOG2) : '0;

    // Data path is a straight pass-through from memory to FIFO while in DATA
    assign in_data            = (state == DATA);
    assign mem_rd_resp_rdy    = (in_data & fifo_wr_rdy) | (state == DRAIN);
    assign fifo_wr_val        = in_data & mem_rd_resp_val;
    assign fifo_wr_data       = fifo_wr_val ? mem_rd_resp_data : '0;
    assign fifo_wr_last       = fifo_wr_val & last_cur;
    assign fifo_wr_entry_last = fifo_wr_last & (remaining == IDX_W'(1));
    assign xfer               = fifo_wr_val & fifo_wr_rdy;

    // Request sequencing: one slot read outstanding at a time
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_idx   <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            need_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val) begin
                        cur_idx   <= req_start_idx;
                        remaining <= req_num_entries;
                        state     <= (req_num_entries == '0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_rd_req_rdy) begin
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        beat_cnt <= CNT_W'(beat_cnt + CNT_W'(1));
                        if (beat_cnt == '0) begin
                            need_q <= need_len;
                        end
                        if (last_cur) begin
                            remaining <= IDX_W'(remaining - IDX_W'(1));
                            cur_idx   <= IDX_W'(cur_idx + IDX_W'(1));
                            if (mem_rd_resp_last) begin
                                state <= (remaining == IDX_W'(1)) ? FINISH : ISSUE;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (mem_rd_resp_val && mem_rd_resp_last) begin
                        state <= (remaining == '0) ? FINISH : ISSUE;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log_entry_fetch_ctrl.sv
// Directed bench for log_entry_fetch_ctrl with a 16-beat slot memory responder.
module tb_log_entry_fetch_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_val = 1'b0;
    logic [15:0]  req_start_idx = '0;
    logic [15:0]  req_num_entries = '0;
    logic         req_rdy;
    logic         mem_rd_req_val;
    logic [31:0]  mem_rd_req_addr;
    logic [31:0]  mem_rd_req_size;
    logic         mem_rd_req_rdy = 1'b1;
    logic         mem_rd_resp_val = 1'b0;
    logic [511:0] mem_rd_resp_data = '0;
    logic         mem_rd_resp_last = 1'b0;
    logic         mem_rd_resp_rdy;
    logic         fifo_wr_val;
    logic [511:0] fifo_wr_data;
    logic         fifo_wr_last;
    logic         fifo_wr_entry_last;
    logic         fifo_wr_rdy = 1'b1;
    logic         busy;
    logic         done;

    log_entry_fetch_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .req_val            (req_val),
        .req_start_idx      (req_start_idx),
        .req_num_entries    (req_num_entries),
        .req_rdy            (req_rdy),
        .mem_rd_req_val     (mem_rd_req_val),
        .mem_rd_req_addr    (mem_rd_req_addr),
        .mem_rd_req_size    (mem_rd_req_size),
        .mem_rd_req_rdy     (mem_rd_req_rdy),
        .mem_rd_resp_val    (mem_rd_resp_val),
        .mem_rd_resp_data   (mem_rd_resp_data),
        .mem_rd_resp_last   (mem_rd_resp_last),
        .mem_rd_resp_rdy    (mem_rd_resp_rdy),
        .fifo_wr_val        (fifo_wr_val),
        .fifo_wr_data       (fifo_wr_data),
        .fifo_wr_last       (fifo_wr_last),
        .fifo_wr_entry_last (fifo_wr_entry_last),
        .fifo_wr_rdy        (fifo_wr_rdy),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory responder / FIFO monitor state
    logic         rsp_active = 1'b0;
    int           beat_k = 0;
    logic [15:0]  cur_len = '0;
    int           slot_no = 0;
    int           resp_beats = 0;
    logic         req_fire = 1'b0;
    logic         beat_fire = 1'b0;
    logic         rst_seen = 1'b1;
    bit           rand_mode = 1'b0;
    logic [15:0]  len_q[$];
    logic [15:0]  exp_lens[$];
    logic [31:0]  addr_log[$];
    logic [511:0] got_data[$];
    logic         got_last[$];
    logic         got_elast[$];

    function automatic logic [511:0] mk_beat(input int slot, input int k, input logic [15:0] len);
        logic [511:0] b;
        b          = '0;
        b[15:0]    = (k == 0) ? len : 16'(32'hA000 + k);
        b[31:16]   = 16'(slot);
        b[39:32]   = 8'(k);
        b[511:504] = 8'(slot ^ k);
        return b;
    endfunction

    function automatic int need_of(input logic [15:0] len);
        int n;
        n = (int'(len) + 63) / 64;
        if (n == 0) n = 1;
        if (n > 16) n = 16;
        return n;
    endfunction

    // Sample handshakes mid-cycle; they complete on the following rising edge
    always @(negedge clk) begin
        req_fire = mem_rd_req_val && mem_rd_req_rdy;
        if (req_fire) addr_log.push_back(mem_rd_req_addr);
        beat_fire = mem_rd_resp_val && mem_rd_resp_rdy;
        if (beat_fire) resp_beats++;
        if (fifo_wr_val && fifo_wr_rdy) begin
            got_data.push_back(fifo_wr_data);
            got_last.push_back(fifo_wr_last);
            got_elast.push_back(fifo_wr_entry_last);
        end
        rst_seen = rst;
    end

    // Drive memory response beats and ready signals just after each rising edge
    always begin
        @(posedge clk);
        #1;
        if (rst_seen) begin
            rsp_active = 1'b0;
            beat_k     = 0;
        end else begin
            if (beat_fire) begin
                if (beat_k == 15) rsp_active = 1'b0;
                else beat_k++;
            end
            if (req_fire) begin
                rsp_active = 1'b1;
                beat_k     = 0;
                cur_len    = (len_q.size() > 0) ? len_q.pop_front() : 16'd0;
                slot_no++;
            end
        end
        mem_rd_resp_val  = rsp_active && (rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
        mem_rd_resp_data = rsp_active ? mk_beat(slot_no, beat_k, cur_len) : '0;
        mem_rd_resp_last = rsp_active && (beat_k == 15);
        fifo_wr_rdy      = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        mem_rd_req_rdy   = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic clr();
        len_q.delete();
        exp_lens.delete();
        addr_log.delete();
        got_data.delete();
        got_last.delete();
        got_elast.delete();
        resp_beats = 0;
    endtask

    task automatic load_len(input logic [15:0] len);
        len_q.push_back(len);
        exp_lens.push_back(len);
    endtask

    task automatic start_req(input logic [15:0] start, input logic [15:0] num);
        @(posedge clk);
        #1;
        req_val         = 1'b1;
        req_start_idx   = start;
        req_num_entries = num;
        @(negedge clk);
        chk("req_rdy_at_accept", 512'(req_rdy), 512'(1));
        @(posedge clk);
        #1;
        req_val = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({tag, "_done"}, 512'(seen), 512'(1));
    endtask

    // Compare captured FIFO stream against the per-entry beat model
    task automatic check_stream(input string tag, input int base, input int n);
        int total;
        int idx;
        int need;
        total = 0;
        idx   = 0;
        for (int e = 0; e < n; e++) total += need_of(exp_lens[e]);
        chk({tag, "_nbeats"}, 512'(got_data.size()), 512'(total));
        for (int e = 0; e < n; e++) begin
            need = need_of(exp_lens[e]);
            for (int k = 0; k < need; k++) begin
                if (idx < got_data.size()) begin
                    chk({tag, "_data"}, got_data[idx], mk_beat(base + 1 + e, k, exp_lens[e]));
                    chk({tag, "_last"}, 512'(got_last[idx]), 512'(k == need - 1));
                    chk({tag, "_elast"}, 512'(got_elast[idx]), 512'((k == need - 1) && (e == n - 1)));
                end
                idx++;
            end
        end
    endtask

    function automatic logic [31:0] addr_at(input int i);
        return (i < addr_log.size()) ? addr_log[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", 512'(req_rdy), 512'(1));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_mem_req_val", 512'(mem_rd_req_val), 512'(0));
        chk("rst_fifo_val", 512'(fifo_wr_val), 512'(0));
        chk("rst_resp_rdy", 512'(mem_rd_resp_rdy), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single entry, len 100: 2 beats forwarded, 14 dropped
        clr();
        load_len(16'd100);
        base = slot_no;
        start_req(16'd5, 16'd1);
        wait_done("a", 200);
        chk("a_nreq", 512'(addr_log.size()), 512'(1));
        chk("a_addr", 512'(addr_at(0)), 512'(32'h0000_1400));
        chk("a_fifo_beats", 512'(got_data.size()), 512'(2));
        chk("a_resp_beats", 512'(resp_beats), 512'(16));
        check_stream("a", base, 1);
        @(negedge clk);
        chk("a_idle_rdy", 512'(req_rdy), 512'(1));
        chk("a_idle_busy", 512'(busy), 512'(0));

        // Ring wrap from index 4095: lens 64 (1 beat) and 200 (4 beats)
        clr();
        load_len(16'd64);
        load_len(16'd200);
        base = slot_no;
        start_req(16'd4095, 16'd2);
        wait_done("b", 300);
        chk("b_nreq", 512'(addr_log.size()), 512'(2));
        chk("b_addr0", 512'(addr_at(0)), 512'(32'h003F_FC00));
        chk("b_addr1", 512'(addr_at(1)), 512'(32'h0000_0000));
        chk("b_fifo_beats", 512'(got_data.size()), 512'(5));
        chk("b_resp_beats", 512'(resp_beats), 512'(32));
        check_stream("b", base, 2);

        // Zero entries: no memory traffic, one busy cycle carrying done
        clr();
        @(posedge clk);
        #1;
        req_val         = 1'b1;
        req_start_idx   = 16'd9;
        req_num_entries = 16'd0;
        @(negedge clk);
        chk("c_accept_rdy", 512'(req_rdy), 512'(1));
        @(posedge clk);
        #1;
        req_val = 1'b0;
        @(negedge clk);
        chk("c_busy1", 512'(busy), 512'(1));
        chk("c_done1", 512'(done), 512'(1));
        chk("c_rdy1", 512'(req_rdy), 512'(0));
        @(negedge clk);
        chk("c_busy2", 512'(busy), 512'(0));
        chk("c_done2", 512'(done), 512'(0));
        chk("c_rdy2", 512'(req_rdy), 512'(1));
        chk("c_nreq", 512'(addr_log.size()), 512'(0));

        // Length boundaries: len 0 -> 1 beat, len 5000 -> clamped to full slot
        clr();
        load_len(16'd0);
        load_len(16'd5000);
        base = slot_no;
        start_req(16'd10, 16'd2);
        wait_done("d", 300);
        chk("d_addr0", 512'(addr_at(0)), 512'(32'h0000_2800));
        chk("d_addr1", 512'(addr_at(1)), 512'(32'h0000_2C00));
        chk("d_fifo_beats", 512'(got_data.size()), 512'(17));
        chk("d_resp_beats", 512'(resp_beats), 512'(32));
        check_stream("d", base, 2);

        // Random back-pressure and response gaps, 8 entries across the ring wrap
        clr();
        load_len(16'd1);
        load_len(16'd65);
        load_len(16'd1024);
        load_len(16'd128);
        load_len(16'd0);
        load_len(16'd640);
        load_len(16'd960);
        load_len(16'd3000);
        base = slot_no;
        rand_mode = 1'b1;
        start_req(16'd4093, 16'd8);
        wait_done("e", 4000);
        rand_mode = 1'b0;
        chk("e_nreq", 512'(addr_log.size()), 512'(8));
        chk("e_addr0", 512'(addr_at(0)), 512'(32'h003F_F400));
        chk("e_addr3", 512'(addr_at(3)), 512'(32'h0000_0000));
        chk("e_addr7", 512'(addr_at(7)), 512'(32'h0000_1000));
        chk("e_fifo_beats", 512'(got_data.size()), 512'(63));
        chk("e_resp_beats", 512'(resp_beats), 512'(128));
        check_stream("e", base, 8);

        // Reset while forwarding data
        clr();
        load_len(16'd1000);
        start_req(16'd7, 16'd1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (fifo_wr_val) seen = 1'b1;
        end
        chk("f_in_data", 512'(seen), 512'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("f_req_rdy", 512'(req_rdy), 512'(1));
        chk("f_busy", 512'(busy), 512'(0));
        chk("f_done", 512'(done), 512'(0));
        chk("f_mem_req_val", 512'(mem_rd_req_val), 512'(0));
        chk("f_mem_req_addr", 512'(mem_rd_req_addr), 512'(0));
        chk("f_fifo_val", 512'(fifo_wr_val), 512'(0));
        chk("f_fifo_last", 512'(fifo_wr_last), 512'(0));
        chk("f_fifo_elast", 512'(fifo_wr_entry_last), 512'(0));
        chk("f_resp_rdy", 512'(mem_rd_resp_rdy), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Recovery after reset: one more single-beat request
        clr();
        load_len(16'd64);
        base = slot_no;
        start_req(16'd1, 16'd1);
        wait_done("g", 200);
        chk("g_addr", 512'(addr_at(0)), 512'(32'h0000_0400));
        check_stream("g", base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
